// File: rtl/md_seq.sv
// md_seq - multi-cycle sequencer for the RV32IM M-extension.
//
// Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request, iterates a
// shared 33-bit add/subtract datapath once per operand bit, and returns the
// XLEN-bit result with a one-cycle done pulse. Divide-by-zero and signed
// overflow finish on a single-cycle fast path without raising busy.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   start   in   request strobe, accepted only when idle and not flushing
//   funct3  in   operation select (000 MUL .. 111 REMU), sampled with start
//   op_a    in   rs1 value (multiplicand / dividend), sampled with start
//   op_b    in   rs2 value (multiplier / divisor), sampled with start
//   flush   in   abort; returns to idle with no done pulse
//   busy    out  high in CALC and FIX (pure state decode)
//   done    out  registered one-cycle completion pulse
//   result  out  registered result, held until the next done
module md_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    localparam logic [4:0] LAST_CNT = 5'(XLEN - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q,  state_d;
    logic [4:0]        cnt_q,    cnt_d;
    logic [2:0]        f3_q,     f3_d;
    logic              neg_q,    neg_d;
    // opnd_q: multiplicand (multiply) or divisor (divide) magnitude.
    // hi_q/lo_q: product high/low halves, or remainder/dividend-quotient.
    logic [XLEN-1:0]   opnd_q,   opnd_d;
    logic [XLEN-1:0]   hi_q,     hi_d;
    logic [XLEN-1:0]   lo_q,     lo_d;
    logic              done_q,   done_d;
    logic [XLEN-1:0]   result_q, result_d;

    // ------------------------------------------------------------------
    // Request decode (operates on the raw inputs in IDLE)
    // ------------------------------------------------------------------
    logic            in_is_div;
    logic            in_a_signed;
    logic            in_b_signed;
    logic            in_sign_a;
    logic            in_sign_b;
    logic [XLEN-1:0] in_mag_a;
    logic [XLEN-1:0] in_mag_b;
    logic            in_div_zero;
    logic            in_overflow;
    logic            in_fast;
    logic [XLEN-1:0] in_fast_val;
    logic            in_neg;

    always_comb begin
        in_is_div   = funct3[2];
        // Signed rs2: MULH, DIV, REM. Signed rs1: those plus MULHSU.
        in_b_signed = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
        in_a_signed = in_b_signed || (funct3 == 3'b010);
        in_sign_a   = in_a_signed && op_a[XLEN-1];
        in_sign_b   = in_b_signed && op_b[XLEN-1];
        in_mag_a    = in_sign_a ? (~op_a + 1'b1) : op_a;
        in_mag_b    = in_sign_b ? (~op_b + 1'b1) : op_b;

        in_div_zero = in_is_div && (op_b == '0);
        in_overflow = in_is_div && !funct3[0]
                      && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (op_b == '1);
        in_fast     = in_div_zero || in_overflow;

        // funct3[1] separates remainder from quotient.
        if (in_div_zero) begin
            in_fast_val = funct3[1] ? op_a : '1;
        end else begin
            in_fast_val = funct3[1] ? '0 : op_a;
        end

        // Remainder takes the dividend sign; products and quotients the XOR.
        in_neg = (in_is_div && funct3[1]) ? in_sign_a : (in_sign_a ^ in_sign_b);
    end

    // ------------------------------------------------------------------
    // Shared 33-bit add/subtract iteration step
    // ------------------------------------------------------------------
    logic              is_div_q;
    logic [XLEN:0]     add_x;
    logic [XLEN:0]     add_y;
    logic [XLEN+1:0]   add_sum;
    logic              no_borrow;
    logic [XLEN-1:0]   hi_step;
    logic [XLEN-1:0]   lo_step;

    always_comb begin
        is_div_q = f3_q[2];
        if (is_div_q) begin
            // Shift the next dividend bit into the partial remainder and
            // trial-subtract the divisor (x + ~y + 1).
            add_x = {hi_q, lo_q[XLEN-1]};
            add_y = ~{1'b0, opnd_q};
        end else begin
            add_x = {1'b0, hi_q};
            add_y = lo_q[0] ? {1'b0, opnd_q} : '0;
        end
        add_sum   = {1'b0, add_x} + {1'b0, add_y} + (XLEN+2)'(is_div_q);
        no_borrow = add_sum[XLEN+1];

        if (is_div_q) begin
            hi_step = no_borrow ? add_sum[XLEN-1:0] : add_x[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], no_borrow};
        end else begin
            // Shift {carry, sum, multiplier} right by one; the consumed
            // multiplier bit drops off the bottom of lo.
            hi_step = add_sum[XLEN:1];
            lo_step = {add_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Final sign fix-up and half select
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   div_mag;
    logic [XLEN-1:0]   div_signed;
    logic [XLEN-1:0]   fix_val;

    always_comb begin
        prod_mag    = {hi_q, lo_q};
        prod_signed = neg_q ? (~prod_mag + 1'b1) : prod_mag;
        div_mag     = f3_q[1] ? hi_q : lo_q;
        div_signed  = neg_q ? (~div_mag + 1'b1) : div_mag;

        if (is_div_q) begin
            fix_val = div_signed;
        end else if (f3_q[1:0] == 2'b00) begin
            fix_val = prod_signed[XLEN-1:0];
        end else begin
            fix_val = prod_signed[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    if (in_fast) begin
                        result_d = in_fast_val;
                        done_d   = 1'b1;
                    end else begin
                        f3_d    = funct3;
                        neg_d   = in_neg;
                        opnd_d  = in_is_div ? in_mag_b : in_mag_a;
                        lo_d    = in_is_div ? in_mag_a : in_mag_b;
                        hi_d    = '0;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                hi_d  = hi_step;
                lo_d  = lo_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_val;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything: back to idle, no pulse, result kept.
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = cnt_q;
            f3_d     = f3_q;
            neg_d    = neg_q;
            opnd_d   = opnd_q;
            hi_d     = hi_q;
            lo_d     = lo_q;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: doc/md_seq.md
# md_seq

Multi-cycle sequencer for the RV32IM M-extension operations. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request from the execute stage and iterates a shared 33-bit add/subtract datapath over XLEN cycles. It holds the pipeline stall line while busy and returns the 32-bit result with a one-cycle done pulse. Divide-by-zero and signed overflow complete on a single-cycle fast path.

## Interface
- XLEN, 32, operand/result width; only 32 is verified.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; accepted only on an edge where busy=0 and flush=0.
- funct3  in  3  operation select, sampled with start.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (multiplicand / dividend), sampled with start.
- op_b  in  XLEN  rs2 value (multiplier / divisor), sampled with start.
- flush  in  1  abort from pipeline control (branch/trap).
- busy  out  1  high in CALC and FIX; the pipeline stalls on it.
- done  out  1  registered one-cycle pulse: result is valid.
- result  out  XLEN  registered result; holds until the next done.

## Operation
- States: IDLE, CALC, FIX. Iteration counter cnt is 5 bits.
- IDLE with start accepted, normal case:
  - Latch funct3.
  - Latch |op_a| and |op_b|. An operand is treated as signed per funct3: MULH both, MULHSU op_a only, DIV/REM both.
  - Latch the result sign: product sign = sign_a XOR sign_b; quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
  - cnt<=0, go to CALC.
- IDLE with start accepted, fast-path cases (stay IDLE, done<=1 next edge):
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
  - DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- CALC, multiply: 64-bit shift-add, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first. Each cycle does a 33-bit trial subtract of the divisor from the partial remainder; the quotient bit is the inverted borrow.
- CALC leaves to FIX when cnt=31 on the edge that performs the last iteration.
- FIX:
  - Two's-complement negate the magnitude if the sign flag is set.
  - Select the output half: MUL -> low 32; MULH/MULHSU/MULHU -> high 32; DIV/DIVU -> quotient; REM/REMU -> remainder.
  - result<=selected value, done<=1, go to IDLE.
- Unsigned variants force the sign flags to 0.
- start while busy=1 is ignored; it is not queued.
- flush in any state: the next edge goes to IDLE, done<=0, result unchanged. flush with start on the same edge: flush wins, start is dropped.
- done is 0 on every edge except the one completing FIX or a fast path.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, busy=0, done=0, result=0, all internal registers 0. Reset mid-operation discards the operation with no done.
- Normal latency, with start sampled at edge E0:
  - CALC covers the iterations on edges E1..E32.
  - FIX is entered after E32.
  - done=1 and result valid in the cycle after E33, i.e. 33 cycles from start.
- busy is high from after E0 through the FIX cycle. It drops together with done rising.
- Fast-path latency: 1 cycle. busy never rises; done=1 in the cycle after E0.
- Back-to-back: a start is accepted in the same cycle done=1, because the block is in IDLE.
- busy is a pure decode of state, with no combinational path from start. The stall for the start cycle itself is asserted by the issuing stage.

## Test plan
- MUL op_a=7, op_b=0xFFFFFFFD (-3) -> busy for 33 cycles, then done=1 for one cycle with result=0xFFFFFFEB; result holds afterward.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast paths, each done 1 cycle after start with busy staying 0:
  - DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Abort and ignored starts:
  - flush on cycle 10 of a DIV -> busy=0 the next cycle, no done pulse, result keeps its previous value.
  - A start issued while busy is ignored.
  - flush+start on the same edge -> stays IDLE.
- Reset and back-to-back:
  - rst=0 asserted mid-CALC -> busy, done and result go to 0 immediately.
  - After release, a new MUL 3x5 completes with 15.
  - A second start issued in the done cycle completes 33 cycles later.
